// File: rtl/ram_param_pkg.sv
// Shared types and constants for the parametrised data memory.
package ram_param_pkg;

  // Clear sequencer states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Default bus widths
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  // Hack memory map
  localparam int RAM_DEPTH   = 16384;
  localparam int SCREEN_BASE = 16384;
  localparam int KBD_ADDR    = 24576;

  // Array index width; a single-word array still needs one index bit
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_param_if.sv
// CPU M-bus plus scan-out port and status flags of the data memory.
interface ram_param_if
  import ram_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              writeM_i;
  logic [ADDR_W-1:0] addressM_i;
  logic [DATA_W-1:0] outM_i;
  logic [DATA_W-1:0] inM_o;
  logic [ADDR_W-1:0] rd2_addr_i;
  logic [DATA_W-1:0] rd2_data_o;
  logic              busy_o;
  logic              oob_err_o;

  // CPU / system side
  modport master (
    output writeM_i, addressM_i, outM_i, rd2_addr_i,
    input  inM_o, rd2_data_o, busy_o, oob_err_o
  );

  // Memory side
  modport slave (
    input  writeM_i, addressM_i, outM_i, rd2_addr_i,
    output inM_o, rd2_data_o, busy_o, oob_err_o
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word once writing zero, then
// hands the array to the CPU.
module ram_clear_seq
  import ram_param_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit CLEAR_ON_RST = 1'b1,
  parameter int IDX_W        = idx_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the clear from word 0
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if (CLEAR_ON_RST) state_q <= ST_CLEAR;
      else              state_q <= ST_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one word per cycle, counter holds at the last word on exit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        if (cnt_q == LAST) state_d = ST_RUN;
        else               cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_param.sv
// Parametrised CPU data memory: M-bus read/write port, registered scan-out
// read port, post-reset clear and sticky out-of-range detection.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = RAM_DEPTH,
  parameter int READ_LAT     = 0,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  ram_param_if.slave  bus
);

  localparam int IDX_W = idx_w(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             clr_we, busy, run;
  logic [IDX_W-1:0] clr_addr;
  logic             cpu_in_rng, rd2_in_rng, cpu_we, mem_we;
  logic [IDX_W-1:0] cpu_idx, rd2_idx, mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd2_q;
  logic             oob_q;

  ram_clear_seq #(
    .DEPTH        (DEPTH),
    .CLEAR_ON_RST (CLEAR_ON_RST),
    .IDX_W        (IDX_W)
  ) u_clr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign run = ~busy;

  // Upper address bits only qualify the range, they never alias into the array
  assign cpu_in_rng = {1'b0, bus.addressM_i} < DEPTH_X;
  assign rd2_in_rng = {1'b0, bus.rd2_addr_i} < DEPTH_X;
  assign cpu_idx    = bus.addressM_i[IDX_W-1:0];
  assign rd2_idx    = bus.rd2_addr_i[IDX_W-1:0];

  // Write port arbitration: the sequencer owns the array while clearing
  always_comb begin
    cpu_we    = run & bus.writeM_i & cpu_in_rng;
    mem_we    = clr_we | cpu_we;
    mem_waddr = clr_we ? clr_addr : cpu_idx;
    mem_wdata = clr_we ? '0 : bus.outM_i;
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Scan-out port: registered, read-first against a same-cycle CPU write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                rd2_q <= '0;
    else if (run && rd2_in_rng)  rd2_q <= mem[rd2_idx];
    else                         rd2_q <= '0;
  end

  // Sticky error: any out-of-range CPU address seen while running
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) oob_q <= 1'b0;
    else          oob_q <= oob_q | (run & ~cpu_in_rng);
  end

  generate
    if (READ_LAT == 0) begin : g_rd_comb
      assign bus.inM_o = (run && cpu_in_rng) ? mem[cpu_idx] : '0;
    end else begin : g_rd_reg
      logic [DATA_W-1:0] rd_q;
      // Registered CPU read, write-first on a same-address write
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)               rd_q <= '0;
        else if (run && cpu_in_rng) rd_q <= bus.writeM_i ? bus.outM_i : mem[cpu_idx];
        else                        rd_q <= '0;
      end
      assign bus.inM_o = rd_q;
    end
  endgenerate

  assign bus.rd2_data_o = rd2_q;
  assign bus.busy_o     = busy;
  assign bus.oob_err_o  = oob_q;

endmodule
